// File: rtl/sccb_slave.sv
// sccb_slave: SCCB register-access slave clocked entirely by the system clock.
// The bus lines are oversampled through a synchronizer chain. START, STOP and
// the sclk edges are derived from the synchronized copies.
// The block answers to DEV_ID. A write carries a sub-address byte followed by
// data bytes. A read streams register bytes starting at the current pointer.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   rst_n      asynchronous active-low reset
//   sccb_sclk  bus clock from the master
//   sccb_data  bus data line; this block only pulls it low or releases it
//   reg_addr   register pointer (persists across transactions)
//   reg_wdata  last received write byte
//   reg_wr_en  one-clk write strobe, reg_addr/reg_wdata valid with it
//   reg_rdata  register contents at reg_addr from the external register file
//   busy       high from an accepted START until STOP
module sccb_slave #(
    parameter logic [6:0] DEV_ID      = 7'h21,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sccb_sclk,
    inout  wire        sccb_data,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr_en,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ID        = 4'd1,
        ID_ACK    = 4'd2,
        SUB       = 4'd3,
        SUB_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        WAIT_STOP = 4'd9
    } state_t;

    state_t               state_r;
    logic [SYNC_STAGES:0] scl_pipe_r;
    logic [SYNC_STAGES:0] sda_pipe_r;
    logic                 scl_s;
    logic                 scl_h;
    logic                 sda_s;
    logic                 sda_h;
    logic                 scl_rise_s;
    logic                 scl_fall_s;
    logic                 start_s;
    logic                 stop_s;
    logic [7:0]           byte_s;
    logic [6:0]           shift_r;
    logic [6:0]           rd_shift_r;
    logic [2:0]           bit_cnt_r;
    logic                 rw_r;
    logic                 ack_on_r;
    logic                 drive_low_r;
    logic [7:0]           reg_addr_r;
    logic [7:0]           reg_wdata_r;
    logic                 reg_wr_en_r;
    logic                 busy_r;

    // The top pipe bit is the history copy. The bit below it is the current synchronized value.
    assign scl_s = scl_pipe_r[SYNC_STAGES-1];
    assign scl_h = scl_pipe_r[SYNC_STAGES];
    assign sda_s = sda_pipe_r[SYNC_STAGES-1];
    assign sda_h = sda_pipe_r[SYNC_STAGES];

    assign scl_rise_s = scl_s & ~scl_h;
    assign scl_fall_s = ~scl_s & scl_h;
    // START and STOP require sclk to be high in both the history and current samples.
    assign start_s    = scl_s & scl_h & sda_h & ~sda_s;
    assign stop_s     = scl_s & scl_h & ~sda_h & sda_s;
    assign byte_s     = {shift_r, sda_s};

    // Open-drain output: pull low or release, never drive high.
    assign sccb_data = drive_low_r ? 1'b0 : 1'bz;

    assign reg_addr  = reg_addr_r;
    assign reg_wdata = reg_wdata_r;
    assign reg_wr_en = reg_wr_en_r;
    assign busy      = busy_r;

    // Bus synchronizers, reset to the idle-bus level so reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_pipe_r <= {(SYNC_STAGES + 1){1'b1}};
            sda_pipe_r <= {(SYNC_STAGES + 1){1'b1}};
        end else begin
            scl_pipe_r <= {scl_pipe_r[SYNC_STAGES-1:0], sccb_sclk};
            sda_pipe_r <= {sda_pipe_r[SYNC_STAGES-1:0], sccb_data};
        end
    end

    // Protocol state machine with registered bus drive and register-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            shift_r     <= 7'h00;
            rd_shift_r  <= 7'h00;
            bit_cnt_r   <= 3'd0;
            rw_r        <= 1'b0;
            ack_on_r    <= 1'b0;
            drive_low_r <= 1'b0;
            reg_addr_r  <= 8'h00;
            reg_wdata_r <= 8'h00;
            reg_wr_en_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            reg_wr_en_r <= 1'b0;
            if (stop_s) begin
                state_r     <= IDLE;
                drive_low_r <= 1'b0;
                ack_on_r    <= 1'b0;
                busy_r      <= 1'b0;
            end else if (start_s) begin
                state_r     <= ID;
                bit_cnt_r   <= 3'd0;
                drive_low_r <= 1'b0;
                ack_on_r    <= 1'b0;
                busy_r      <= 1'b1;
            end else begin
                case (state_r)
                    ID, SUB, WDATA: begin
                        if (scl_rise_s) begin
                            shift_r   <= byte_s[6:0];
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            // The counter wraps from 7 to 0 on the eighth bit, which completes the byte.
                            if (bit_cnt_r == 3'd7) begin
                                ack_on_r <= 1'b0;
                                if (state_r == ID) begin
                                    if (byte_s[7:1] == DEV_ID) begin
                                        rw_r    <= byte_s[0];
                                        state_r <= ID_ACK;
                                    end else begin
                                        state_r <= WAIT_STOP;
                                    end
                                end else if (state_r == SUB) begin
                                    reg_addr_r <= byte_s;
                                    state_r    <= SUB_ACK;
                                end else begin
                                    reg_wdata_r <= byte_s;
                                    reg_wr_en_r <= 1'b1;
                                    state_r     <= WDATA_ACK;
                                end
                            end
                        end
                    end
                    ID_ACK, SUB_ACK, WDATA_ACK: begin
                        // The first falling edge starts the ACK low. The second ends it.
                        if (scl_fall_s) begin
                            if (!ack_on_r) begin
                                drive_low_r <= 1'b1;
                                ack_on_r    <= 1'b1;
                            end else begin
                                ack_on_r  <= 1'b0;
                                bit_cnt_r <= 3'd0;
                                if (state_r == ID_ACK && rw_r) begin
                                    // The MSB of the read byte goes out on the same edge that ends the ACK.
                                    drive_low_r <= ~reg_rdata[7];
                                    rd_shift_r  <= reg_rdata[6:0];
                                    state_r     <= RDATA;
                                end else if (state_r == WDATA_ACK) begin
                                    drive_low_r <= 1'b0;
                                    reg_addr_r  <= reg_addr_r + 8'd1;
                                    state_r     <= WDATA;
                                end else if (state_r == SUB_ACK) begin
                                    drive_low_r <= 1'b0;
                                    state_r     <= WDATA;
                                end else begin
                                    drive_low_r <= 1'b0;
                                    state_r     <= SUB;
                                end
                            end
                        end
                    end
                    RDATA: begin
                        // The remaining seven bits go out on the next seven falls. The eighth fall releases the line.
                        if (scl_fall_s) begin
                            if (bit_cnt_r == 3'd7) begin
                                drive_low_r <= 1'b0;
                                bit_cnt_r   <= 3'd0;
                                ack_on_r    <= 1'b0;
                                state_r     <= RDATA_ACK;
                            end else begin
                                drive_low_r <= ~rd_shift_r[6];
                                rd_shift_r  <= {rd_shift_r[5:0], 1'b1};
                                bit_cnt_r   <= bit_cnt_r + 3'd1;
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise_s) begin
                            if (!sda_s) begin
                                reg_addr_r <= reg_addr_r + 8'd1;
                                ack_on_r   <= 1'b1;
                            end else begin
                                state_r <= WAIT_STOP;
                            end
                        end else if (scl_fall_s && ack_on_r) begin
                            // reg_rdata has followed the incremented pointer for a full sclk half-period.
                            ack_on_r    <= 1'b0;
                            drive_low_r <= ~reg_rdata[7];
                            rd_shift_r  <= reg_rdata[6:0];
                            bit_cnt_r   <= 3'd0;
                            state_r     <= RDATA;
                        end
                    end
                    IDLE, WAIT_STOP: begin
                        drive_low_r <= 1'b0;
                    end
                    default: begin
                        state_r     <= IDLE;
                        drive_low_r <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_slave.sv
// tb_sccb_slave: directed and randomized SCCB master transactions against sccb_slave.
// The bench plays the bus master. It also acts as the external register file that
// sccb_slave reads and writes. A behavioural model (register array plus pointer)
// predicts every write strobe and every read byte.
module tb_sccb_slave;

    localparam int Q = 5;   // quarter of an sclk period in clk cycles (half-period = 10 clk)

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scl;
    logic        sda_low;
    wire         sda_bus;
    logic [7:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_wr_en;
    logic [7:0]  reg_rdata;
    logic        busy;

    logic [7:0]  mem [256];
    logic        mem_ready = 1'b0;
    logic [15:0] obs_w [256];
    int          obs_n = 0;
    int          wide_pulses = 0;
    logic        wr_prev = 1'b0;
    int          dut_low_cnt = 0;
    int          bus_high_cnt = 0;

    logic [7:0]  model_mem [256];
    logic [7:0]  model_ptr;
    logic [15:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #20 clk = ~clk;

    assign sda_bus = sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);
    assign reg_rdata = mem[reg_addr];

    sccb_slave #(.DEV_ID(7'h21), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sccb_sclk (scl),
        .sccb_data (sda_bus),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr_en (reg_wr_en),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    function automatic logic [7:0] init_val(input int i);
        if (i == 10) return 8'h76;
        return 8'(i * 37 + 11);
    endfunction

    // External register file and write-strobe recorder.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (reg_wr_en) begin
            mem[reg_addr]       <= reg_wdata;
            obs_w[obs_n[7:0]]   <= {reg_addr, reg_wdata};
            obs_n               <= obs_n + 1;
        end
        if (reg_wr_en && wr_prev) wide_pulses <= wide_pulses + 1;
        wr_prev <= reg_wr_en;
    end

    // Bus watcher: the slave pulling low while the master is released, and the line not low while the master pulls.
    always @(negedge clk) begin
        if (!sda_low && sda_bus === 1'b0) dut_low_cnt <= dut_low_cnt + 1;
        if (sda_low && sda_bus !== 1'b0) bus_high_cnt <= bus_high_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        sda_low = 1'b0; wait_q();
        scl = 1'b1;     wait_q();
        sda_low = 1'b1; wait_q();
        scl = 1'b0;     wait_q();
    endtask

    task automatic bus_stop();
        sda_low = 1'b1; wait_q();
        scl = 1'b1;     wait_q();
        sda_low = 1'b0; wait_q();
        wait_q();
    endtask

    task automatic put_bit(input logic b);
        sda_low = ~b; wait_q();
        scl = 1'b1;   wait_q(); wait_q();
        scl = 1'b0;   wait_q();
    endtask

    task automatic get_bit(output logic b);
        sda_low = 1'b0; wait_q();
        scl = 1'b1;     wait_q();
        b = sda_bus;    wait_q();
        scl = 1'b0;     wait_q();
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(b);
        ack = ~b;
    endtask

    task automatic get_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(~ack);
    endtask

    // Model of one accepted data byte: store it at the pointer, then advance the pointer (8-bit wrap).
    task automatic model_write(input logic [7:0] d);
        exp_q.push_back({model_ptr, d});
        model_mem[model_ptr] = d;
        model_ptr = model_ptr + 8'd1;
    endtask

    task automatic check_writes(input string tag, input int base);
        check({tag, " wr_count"}, 32'(obs_n - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < obs_n)
                check({tag, " wr_entry"}, {16'h0, obs_w[8'(base + i)]}, {16'h0, exp_q[i]});
        exp_q.delete();
    endtask

    initial begin
        logic       a0, a1, a2, a3, bit_in;
        logic [7:0] rb, sub;
        int         base, lows, n;

        for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
        model_ptr = 8'h00;
        rst_n = 1'b0; scl = 1'b1; sda_low = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset reg_addr", 32'(reg_addr), 32'h00);
        check("reset reg_wdata", 32'(reg_wdata), 32'h00);
        check("reset reg_wr_en", 32'(reg_wr_en), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset sda released", 32'(sda_bus), 32'h1);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Basic write: 42 12 80.
        base = obs_n;
        bus_start();
        check("t1 busy after start", 32'(busy), 32'h1);
        put_byte(8'h42, a0); put_byte(8'h12, a1); model_ptr = 8'h12;
        put_byte(8'h80, a2); model_write(8'h80);
        check("t1 acks", 32'({a0, a1, a2}), 32'h7);
        bus_stop();
        check("t1 busy after stop", 32'(busy), 32'h0);
        check_writes("t1", base);

        // Wrong device ID: silent, no strobe, pointer untouched.
        base = obs_n; lows = dut_low_cnt;
        bus_start();
        put_byte(8'h44, a0); put_byte(8'h12, a1); put_byte(8'h80, a2);
        bus_stop();
        check("t2 acks", 32'({a0, a1, a2}), 32'h0);
        check("t2 slave never low", 32'(dut_low_cnt - lows), 32'h0);
        check("t2 reg_addr", 32'(reg_addr), 32'(model_ptr));
        check_writes("t2", base);

        // Set the pointer to 0A, then read one byte with NACK.
        base = obs_n;
        bus_start(); put_byte(8'h42, a0); put_byte(8'h0A, a1); model_ptr = 8'h0A; bus_stop();
        bus_start(); put_byte(8'h43, a2);
        get_byte(rb, 1'b0);
        check("t3 acks", 32'({a0, a1, a2}), 32'h7);
        check("t3 read byte", 32'(rb), 32'(model_mem[model_ptr]));
        check("t3 read pattern 76", 32'(rb), 32'h76);
        get_byte(rb, 1'b0);
        check("t3 released after nack", 32'(rb), 32'hFF);
        check("t3 busy in wait_stop", 32'(busy), 32'h1);
        bus_stop();
        check("t3 reg_addr", 32'(reg_addr), 32'(model_ptr));
        check_writes("t3", base);

        // Multi-byte write across the pointer wrap.
        base = obs_n;
        bus_start(); put_byte(8'h42, a0); put_byte(8'hFE, a1); model_ptr = 8'hFE;
        put_byte(8'h11, a2); model_write(8'h11);
        put_byte(8'h22, a3); model_write(8'h22);
        check("t4 acks", 32'({a0, a1, a2, a3}), 32'hF);
        put_byte(8'h33, a0); model_write(8'h33);
        bus_stop();
        check("t4 last ack", 32'(a0), 32'h1);
        check("t4 reg_addr wrapped", 32'(reg_addr), 32'(model_ptr));
        check_writes("t4", base);

        // Repeated START after four SUB bits aborts that frame.
        base = obs_n;
        bus_start(); put_byte(8'h42, a0);
        put_bit(1'b0); put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
        bus_start(); put_byte(8'h42, a1); put_byte(8'h05, a2); model_ptr = 8'h05;
        put_byte(8'h9C, a3); model_write(8'h9C);
        bus_stop();
        check("t5 acks", 32'({a0, a1, a2, a3}), 32'hF);
        check_writes("t5", base);

        // Randomized bursts: write n bytes, then read them back from the model's view.
        for (int it = 0; it < 4; it++) begin
            base = obs_n;
            sub = 8'($urandom_range(0, 255));
            n = int'($urandom_range(1, 4));
            bus_start(); put_byte(8'h42, a0); put_byte(sub, a1); model_ptr = sub;
            for (int k = 0; k < n; k++) begin
                rb = 8'($urandom);
                put_byte(rb, a2);
                model_write(rb);
            end
            bus_stop();
            check("rnd write acks", 32'({a0, a1, a2}), 32'h7);
            bus_start(); put_byte(8'h42, a0); put_byte(sub, a1); model_ptr = sub; bus_stop();
            bus_start(); put_byte(8'h43, a2);
            for (int k = 0; k < n; k++) begin
                get_byte(rb, (k != n - 1));
                check("rnd read byte", 32'(rb), 32'(model_mem[model_ptr]));
                if (k != n - 1) model_ptr = model_ptr + 8'd1;
            end
            bus_stop();
            check("rnd read acks", 32'({a0, a1, a2}), 32'h7);
            check("rnd reg_addr", 32'(reg_addr), 32'(model_ptr));
            check_writes("rnd", base);
        end

        // Reset while the slave drives an ACK low: the line is released at once.
        base = obs_n;
        bus_start(); put_byte(8'h42, a0);
        for (int i = 7; i >= 0; i--) put_bit(i[0]);
        sda_low = 1'b0; wait_q();
        check("t6 ack low before reset", 32'(sda_bus), 32'h0);
        rst_n = 1'b0; #1;
        check("t6 sda released on reset", 32'(sda_bus), 32'h1);
        check("t6 reg_addr reset", 32'(reg_addr), 32'h00);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        scl = 1'b1; wait_q(); wait_q(); scl = 1'b0; wait_q();
        bus_stop();
        model_ptr = 8'h00;
        check_writes("t6", base);

        // Reset during bit 5 of WDATA: no strobe, pointer back to 0, bus ignored until next START.
        base = obs_n;
        bus_start(); put_byte(8'h42, a0); put_byte(8'h33, a1);
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
        sda_low = 1'b0; wait_q();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t7 sda released", 32'(sda_bus), 32'h1);
        check("t7 busy cleared", 32'(busy), 32'h0);
        check("t7 reg_addr reset", 32'(reg_addr), 32'h00);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        scl = 1'b1; wait_q(); wait_q(); scl = 1'b0; wait_q();
        put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
        get_bit(bit_in);
        bus_stop();
        model_ptr = 8'h00;
        check("t7 no ack after reset", 32'(bit_in), 32'h1);
        check("t7 reg_addr", 32'(reg_addr), 32'(model_ptr));
        check_writes("t7", base);

        check("strobe width", 32'(wide_pulses), 32'h0);
        check("never driven high", 32'(bus_high_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sccb_slave.md
SCCB_SLAVE -- requirements
Module: sccb_slave

Interface
REQ-001 The module SHALL have parameter DEV_ID, default 7'h21, giving the 7-bit device address it answers to (write ID 8'h42, read ID 8'h43).
REQ-002 The module SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth applied to sccb_sclk and sccb_data.
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock (25 MHz nominal); all logic is on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port sccb_sclk, input, 1 bit: the bus clock from the master.
REQ-006 The module SHALL have port sccb_data, inout, 1 bit: the bus data line; this block drives only 0 or z on it.
REQ-007 The module SHALL have port reg_addr, output, 8 bits: the current register pointer.
REQ-008 The module SHALL have port reg_wdata, output, 8 bits: the received write byte.
REQ-009 The module SHALL have port reg_wr_en, output, 1 bit: a one-clk write strobe.
REQ-010 The module SHALL have port reg_rdata, input, 8 bits: register contents at reg_addr, combinational from the external register file.
REQ-011 The module SHALL have port busy, output, 1 bit: high from an accepted START until STOP.

Function
REQ-012 sccb_sclk and sccb_data SHALL pass through SYNC_STAGES flops plus one history flop; all edge and condition detection SHALL use the synchronized values only.
REQ-013 Correct operation SHALL be guaranteed when each sccb_sclk half-period is at least 8 clk periods.
REQ-014 A START condition SHALL be detected when synchronized data falls while synchronized sclk is high; a STOP condition SHALL be detected when data rises while sclk is high.
REQ-015 A STOP in any state SHALL cause: state->IDLE, sccb_data released, busy=0.
REQ-016 A START in any state, including a repeated start, SHALL cause: state->ID, bit count cleared, busy=1.
REQ-017 The state machine SHALL have states IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK and WAIT_STOP.
REQ-018 In the ID, SUB and WDATA states, bits SHALL be sampled MSB first on synchronized sclk rising edges; a 3-bit counter SHALL mark byte completion after 8 bits.
REQ-019 ID byte, case [7:1]==DEV_ID: the block SHALL go to ID_ACK.
REQ-020 ID byte, case mismatch: the block SHALL go to WAIT_STOP, never drive the bus and issue no strobe.
REQ-021 ID_ACK, SUB_ACK and WDATA_ACK SHALL drive sccb_data=0 from the sclk falling edge after the 8th bit until the next sclk falling edge, then release it.
REQ-022 After ID_ACK, R/W bit=0 SHALL lead to SUB and R/W bit=1 SHALL lead to RDATA.
REQ-023 After SUB is complete, reg_addr SHALL equal the received byte, and the block SHALL go to SUB_ACK and then WDATA.
REQ-024 When WDATA is complete, reg_wdata SHALL be loaded and reg_wr_en SHALL pulse for exactly 1 clk, no later than 2 clk after the 8th sampling edge, with reg_addr valid during the pulse.
REQ-025 reg_addr SHALL increment on the sclk falling edge that ends WDATA_ACK, wrapping 8'hFF->8'h00, and the block SHALL then return to WDATA for the next byte.
REQ-026 RDATA SHALL capture reg_rdata into a shift register on the falling edge that ends ID_ACK or RDATA_ACK.
REQ-027 RDATA SHALL present each bit on sccb_data on successive sclk falling edges, MSB first, driving 0 for a 0 bit and releasing (z) for a 1 bit.
REQ-028 After the 8th read bit, sccb_data SHALL be released and the master ACK SHALL be sampled on the next sclk rising edge in RDATA_ACK.
REQ-029 Master ACK (0) SHALL cause reg_addr+1 (with wrap) followed by RDATA; master NACK (1) SHALL cause WAIT_STOP.
REQ-030 reg_addr SHALL persist across transactions, so that a write of the sub-address alone followed by a read returns that register.
REQ-031 A STOP or START received mid-byte SHALL abort that byte with no reg_wr_en pulse and no reg_addr change.
REQ-032 sccb_data SHALL never be driven to 1.

Reset
REQ-033 While rst_n=0, the block SHALL hold: state=IDLE, sccb_data=z, reg_addr=8'h00, reg_wdata=8'h00, reg_wr_en=0, busy=0, and all synchronizer flops at 1 (idle bus).
REQ-034 Assertion of rst_n mid-transfer SHALL immediately release sccb_data, and the block SHALL ignore bus activity until the next START after rst_n returns to 1.

Verification
REQ-035 Write 8'h42, 8'h12, 8'h80, STOP -> three ACK lows; one reg_wr_en pulse with reg_addr=8'h12 and reg_wdata=8'h80; busy falls after STOP.
REQ-036 Write 8'h44, 8'h12, 8'h80 -> sccb_data never driven low; no reg_wr_en; reg_addr unchanged.
REQ-037 Write 8'h42, 8'h0A, STOP; then 8'h43 with reg_rdata=8'h76, master NACK -> bus shows 0,1,1,1,0,1,1,0; block releases sccb_data and goes to WAIT_STOP.
REQ-038 Write 8'h42, 8'hFE, then data bytes 8'h11, 8'h22, 8'h33 -> writes land at 8'hFE, 8'hFF and 8'h00 (wrap).
REQ-039 Repeated START after 4 bits of SUB, then 8'h42, 8'h05, 8'h9C -> no write from the aborted frame; a single write to 8'h05 with data 8'h9C.
REQ-040 rst_n pulsed low during bit 5 of WDATA -> sccb_data=z within 1 clk; no reg_wr_en; reg_addr=8'h00.
